bpu_bht: RTL and testbench

Branch history table on the prediction side of the branch-unit protocol.
- Fetch side: serves `pred_taken` lookups.
- Branch-unit side: consumes resolution results (`res_*`) through a small update FIFO, trains 2-bit saturating counters and issues a one-cycle fetch redirect on mispredict.
- The table is single-ported. Lookups have priority over training writes, so pending updates are buffered.

---
 rtl/bpu_bht.sv | 240 ++++++++++++++++++++++++
 tb/tb_bpu_bht.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_bht.sv
// bpu_bht: branch history table on the prediction side of the branch unit.
// A single-ported table of 2-bit saturating counters serves fetch lookups,
// while resolutions from the branch unit are queued in a small update FIFO
// and trained into the table only in cycles without an accepted lookup.
// Mispredicted resolutions produce a one-cycle fetch redirect.
// Optional feature: define BPU_BHT_GSHARE_EN to XOR a global history
// register into both the lookup and the training index.
module bpu_bht #(
  parameter int XLEN      = 64,
  parameter int BHT_BITS  = 6,
  parameter int UPD_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            pred_valid_i,
  input  logic [XLEN-1:0] pred_pc_i,
  output logic            pred_ready_o,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            res_valid_i,
  output logic            res_ready_o,
  input  logic [XLEN-1:0] res_pc_i,
  input  logic [XLEN-1:0] res_target_i,
  input  logic            res_taken_i,
  input  logic            res_mispredict_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam int ENTRIES = 1 << BHT_BITS;
  localparam int PTR_W   = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [BHT_BITS-1:0]   init_idx_q;
  logic [BHT_BITS-1:0]   init_idx_d;

  logic                  run;
  logic                  lookup_acc;
  logic                  res_acc;
  logic [BHT_BITS-1:0]   lk_idx;
  logic [BHT_BITS-1:0]   push_idx;

  logic [BHT_BITS-1:0]   fifo_idx   [UPD_DEPTH];
  logic                  fifo_taken [UPD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;

  logic [1:0]            bht [ENTRIES];
  logic [BHT_BITS-1:0]   head_idx;
  logic                  head_taken;
  logic [1:0]            head_ctr;
  logic [1:0]            upd_ctr;
  logic [1:0]            rd_ctr;
  logic                  tbl_we;
  logic [BHT_BITS-1:0]   tbl_waddr;
  logic [1:0]            tbl_wdata;

  // Only the index bits of the lookup PC select a counter; the rest are ignored.
  logic                  unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc_i[XLEN-1:BHT_BITS+2], pred_pc_i[1:0]};

  function automatic logic [BHT_BITS-1:0] pc_idx(input logic [XLEN-1:0] pc);
    return pc[BHT_BITS+1:2];
  endfunction

  // Handshakes: both sides are held off until the table has been initialised,
  // and resolutions are refused whenever the update FIFO is full.
  assign run          = (state_q == ST_RUN);
  assign pred_ready_o = run;
  assign lookup_acc   = pred_valid_i && run;
  assign fifo_full    = (count_q == CNT_W'(UPD_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign res_ready_o  = run && !fifo_full;
  assign res_acc      = res_valid_i && res_ready_o;
  assign pop          = run && !fifo_empty && !lookup_acc;

`ifdef BPU_BHT_GSHARE_EN
  logic [BHT_BITS-1:0]   ghr;

  // Global history shifts in each accepted resolution direction.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ghr <= '0;
    end else if (res_acc) begin
      ghr <= {ghr[BHT_BITS-2:0], res_taken_i};
    end
  end

  assign lk_idx   = pc_idx(pred_pc_i) ^ ghr;
  assign push_idx = pc_idx(res_pc_i) ^ ghr;
`else
  assign lk_idx   = pc_idx(pred_pc_i);
  assign push_idx = pc_idx(res_pc_i);
`endif

  // Next-state logic: sweep every entry once in INIT, then stay in RUN.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      ST_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == {BHT_BITS{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // FSM state and the init sweep pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Update FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (res_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({res_acc, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Update FIFO payload storage; stale slots are never read, so no reset.
  always_ff @(posedge clk_i) begin
    if (res_acc) begin
      fifo_idx[wr_ptr_q]   <= push_idx;
      fifo_taken[wr_ptr_q] <= res_taken_i;
    end
  end

  assign head_idx   = fifo_idx[rd_ptr_q];
  assign head_taken = fifo_taken[rd_ptr_q];
  assign head_ctr   = bht[head_idx];
  assign rd_ctr     = bht[lk_idx];

  // Saturating increment or decrement of the counter at the FIFO head.
  always_comb begin
    upd_ctr = head_ctr;
    if (head_taken) begin
      if (head_ctr != 2'b11) begin
        upd_ctr = head_ctr + 2'b01;
      end
    end else begin
      if (head_ctr != 2'b00) begin
        upd_ctr = head_ctr - 2'b01;
      end
    end
  end

  // Single table write port, shared between the init sweep and FIFO training.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = 2'b01;
    if (state_q == ST_INIT) begin
      tbl_we    = 1'b1;
      tbl_waddr = init_idx_q;
      tbl_wdata = 2'b01;
    end else if (pop) begin
      tbl_we    = 1'b1;
      tbl_waddr = head_idx;
      tbl_wdata = upd_ctr;
    end
  end

  // Counter table; init sweep guarantees defined contents before RUN.
  always_ff @(posedge clk_i) begin
    if (tbl_we) begin
      bht[tbl_waddr] <= tbl_wdata;
    end
  end

  // Registered lookup result; a flush suppresses the result and keeps the old direction.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
    end else begin
      pred_valid_o <= lookup_acc && !flush_i;
      if (lookup_acc && !flush_i) begin
        pred_taken_o <= rd_ctr[1];
      end
    end
  end

  // One-cycle redirect for mispredicted resolutions; the address holds otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      redirect_valid_o <= res_acc && res_mispredict_i;
      if (res_acc && res_mispredict_i) begin
        redirect_pc_o <= res_taken_i ? res_target_i : (res_pc_i + XLEN'(4));
      end
    end
  end

  // Occupancy can never exceed the FIFO depth.
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    count_q <= CNT_W'(UPD_DEPTH));

endmodule

// File: tb/tb_bpu_bht.sv
// tb_bpu_bht: scoreboard bench for bpu_bht (default build, PC indexing).
module tb_bpu_bht;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst_n_i;
  logic            flush_i;
  logic            pred_valid_i;
  logic [XLEN-1:0] pred_pc_i;
  logic            pred_ready_o;
  logic            pred_valid_o;
  logic            pred_taken_o;
  logic            res_valid_i;
  logic            res_ready_o;
  logic [XLEN-1:0] res_pc_i;
  logic [XLEN-1:0] res_target_i;
  logic            res_taken_i;
  logic            res_mispredict_i;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;

  typedef struct {
    int   due;
    logic taken;
  } pred_exp_t;

  typedef struct {
    int              due;
    logic [XLEN-1:0] pc;
  } redir_exp_t;

  pred_exp_t  pred_q[$];
  redir_exp_t redir_q[$];

  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;
  bit              mon_en = 0;
  logic            exp_taken_hold = 1'b0;
  logic [XLEN-1:0] exp_redir_pc = '0;

  bpu_bht #(
    .XLEN(XLEN),
    .BHT_BITS(6),
    .UPD_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n_i),
    .flush_i(flush_i),
    .pred_valid_i(pred_valid_i),
    .pred_pc_i(pred_pc_i),
    .pred_ready_o(pred_ready_o),
    .pred_valid_o(pred_valid_o),
    .pred_taken_o(pred_taken_o),
    .res_valid_i(res_valid_i),
    .res_ready_o(res_ready_o),
    .res_pc_i(res_pc_i),
    .res_target_i(res_target_i),
    .res_taken_i(res_taken_i),
    .res_mispredict_i(res_mispredict_i),
    .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp scoreboard entries.
  always @(posedge clk) cyc <= cyc + 1;

  // Reset clears the held output values the monitor expects.
  always @(posedge clk) begin
    if (!rst_n_i) begin
      exp_taken_hold = 1'b0;
      exp_redir_pc   = '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Monitor: compare outputs against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_pv;
      logic exp_rv;
      exp_pv = (pred_q.size() > 0) && (pred_q[0].due == cyc);
      if (exp_pv) begin
        exp_taken_hold = pred_q[0].taken;
        void'(pred_q.pop_front());
      end
      checkOutput("pred_valid", XLEN'(pred_valid_o), XLEN'(exp_pv));
      checkOutput("pred_taken", XLEN'(pred_taken_o), XLEN'(exp_taken_hold));
      exp_rv = (redir_q.size() > 0) && (redir_q[0].due == cyc);
      if (exp_rv) begin
        exp_redir_pc = redir_q[0].pc;
        void'(redir_q.pop_front());
      end
      checkOutput("redirect_valid", XLEN'(redirect_valid_o), XLEN'(exp_rv));
      checkOutput("redirect_pc", redirect_pc_o, exp_redir_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    flush_i          = 1'b0;
    pred_valid_i     = 1'b0;
    pred_pc_i        = '0;
    res_valid_i      = 1'b0;
    res_pc_i         = '0;
    res_target_i     = '0;
    res_taken_i      = 1'b0;
    res_mispredict_i = 1'b0;
  endtask

  task automatic applyStimulus(input bit pv, input logic [XLEN-1:0] ppc, input bit fl,
                               input bit rv, input logic [XLEN-1:0] rpc,
                               input logic [XLEN-1:0] rtgt, input bit rt, input bit rm);
    pred_valid_i     = pv;
    pred_pc_i        = ppc;
    flush_i          = fl;
    res_valid_i      = rv;
    res_pc_i         = rpc;
    res_target_i     = rtgt;
    res_taken_i      = rt;
    res_mispredict_i = rm;
    tick();
    clearInputs();
  endtask

  task automatic idle(input int n);
    clearInputs();
    repeat (n) tick();
  endtask

  task automatic lookup(input logic [XLEN-1:0] pc, input logic exp_taken);
    pred_exp_t e;
    e.due   = cyc + 1;
    e.taken = exp_taken;
    pred_q.push_back(e);
    applyStimulus(1'b1, pc, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                         input bit taken, input bit mispred);
    redir_exp_t r;
    if (mispred) begin
      r.due = cyc + 1;
      r.pc  = taken ? tgt : pc + 64'd4;
      redir_q.push_back(r);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, pc, tgt, taken, mispred);
  endtask

  // Release reset in the current cycle and walk through the 64-cycle init sweep.
  task automatic runInitCheck();
    rst_n_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      clearInputs();
      if (i == 10) begin
        pred_valid_i     = 1'b1;
        pred_pc_i        = 64'h100;
        res_valid_i      = 1'b1;
        res_pc_i         = 64'h100;
        res_target_i     = 64'h4000;
        res_taken_i      = 1'b1;
        res_mispredict_i = 1'b1;
      end
      checkOutput("pred_ready_init", XLEN'(pred_ready_o), '0);
      if (i == 10 || i == 63) begin
        checkOutput("res_ready_init", XLEN'(res_ready_o), '0);
      end
      tick();
    end
    clearInputs();
    checkOutput("pred_ready_run", XLEN'(pred_ready_o), 64'd1);
    checkOutput("res_ready_run", XLEN'(res_ready_o), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pred_exp_t pe;
    clearInputs();
    rst_n_i = 1'b0;
    tick();
    mon_en = 1;
    tick();
    tick();

    // Reset values.
    checkOutput("rst_pred_valid", XLEN'(pred_valid_o), '0);
    checkOutput("rst_pred_taken", XLEN'(pred_taken_o), '0);
    checkOutput("rst_redirect_valid", XLEN'(redirect_valid_o), '0);
    checkOutput("rst_redirect_pc", redirect_pc_o, '0);
    checkOutput("rst_pred_ready", XLEN'(pred_ready_o), '0);
    checkOutput("rst_res_ready", XLEN'(res_ready_o), '0);

    // Init sweep, then first lookup sees weakly not-taken.
    runInitCheck();
    lookup(64'h100, 1'b0);

    // Two taken resolutions push entry 0 to strongly taken.
    resolve(64'h100, 64'h0, 1'b1, 1'b0);
    resolve(64'h100, 64'h0, 1'b1, 1'b0);
    idle(3);
    lookup(64'h100, 1'b1);
    lookup(64'h104, 1'b0);

    // Flushed lookup produces no result.
    applyStimulus(1'b1, 64'h104, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    lookup(64'h104, 1'b0);

    // Saturate at zero, then climb back.
    for (int i = 0; i < 5; i++) resolve(64'h108, 64'h0, 1'b0, 1'b0);
    resolve(64'h108, 64'h0, 1'b1, 1'b0);
    idle(3);
    lookup(64'h108, 1'b0);
    resolve(64'h108, 64'h0, 1'b1, 1'b0);
    resolve(64'h108, 64'h0, 1'b1, 1'b0);
    idle(3);
    lookup(64'h108, 1'b1);

    // Redirects: taken target, held address on a correct prediction, wrapped fall-through.
    resolve(64'h1000, 64'h2000, 1'b1, 1'b1);
    idle(2);
    resolve(64'h200, 64'h300, 1'b1, 1'b0);
    idle(2);
    resolve(64'hFFFF_FFFF_FFFF_FFFC, 64'h5000, 1'b0, 1'b1);
    idle(2);

    // Lookups starve the FIFO until it fills, then it drains.
    for (int i = 0; i < 10; i++) begin
      pred_valid_i     = (i < 8);
      pred_pc_i        = 64'h104;
      res_valid_i      = 1'b1;
      res_pc_i         = 64'h10C;
      res_target_i     = 64'h0;
      res_taken_i      = 1'b1;
      res_mispredict_i = 1'b0;
      if (i < 8) begin
        pe.due   = cyc + 1;
        pe.taken = 1'b0;
        pred_q.push_back(pe);
      end
      checkOutput($sformatf("res_ready_fill%0d", i), XLEN'(res_ready_o),
                  XLEN'((i < 4) || (i == 9)));
      checkOutput("pred_ready_fill", XLEN'(pred_ready_o), 64'd1);
      tick();
    end
    idle(6);
    lookup(64'h10C, 1'b1);

    // Reset mid-operation with pending FIFO entries and a redirect due.
    for (int i = 0; i < 3; i++) begin
      pred_valid_i     = 1'b1;
      pred_pc_i        = 64'h104;
      res_valid_i      = 1'b1;
      res_pc_i         = (i == 2) ? 64'h114 : 64'h110;
      res_target_i     = 64'h3000;
      res_taken_i      = 1'b1;
      res_mispredict_i = (i == 2);
      if (i < 2) begin
        pe.due   = cyc + 1;
        pe.taken = 1'b0;
        pred_q.push_back(pe);
      end else begin
        rst_n_i = 1'b0;
      end
      tick();
    end
    clearInputs();
    checkOutput("rst2_pred_valid", XLEN'(pred_valid_o), '0);
    checkOutput("rst2_redirect_valid", XLEN'(redirect_valid_o), '0);
    checkOutput("rst2_redirect_pc", redirect_pc_o, '0);
    checkOutput("rst2_pred_taken", XLEN'(pred_taken_o), '0);
    runInitCheck();
    lookup(64'h100, 1'b0);
    lookup(64'h110, 1'b0);
    lookup(64'h10C, 1'b0);
    idle(3);

    mon_en = 0;
    checkOutput("pred_queue_empty", 64'(pred_q.size()), '0);
    checkOutput("redir_queue_empty", 64'(redir_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
